// File: rtl/edge_det_pkg.sv
// Shared definitions for the multi-channel edge detector: mode encodings and
// the filter counter width helper.
package edge_det_pkg;

   localparam logic [1:0] MODE_OFF  = 2'b00;
   localparam logic [1:0] MODE_RISE = 2'b01;
   localparam logic [1:0] MODE_FALL = 2'b10;
   localparam logic [1:0] MODE_BOTH = 2'b11;

   // Wide enough to hold FILTER_LEN; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned filter_len);
      int unsigned w;
      w = $clog2(filter_len + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/edge_det_chan.sv
// One edge-detector channel: synchroniser, stable-count glitch filter,
// mode-gated single-cycle pulses and a sticky event flag.
module edge_det_chan
   import edge_det_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILTER_LEN  = 1,
   parameter logic        RST_LVL     = 1'b0
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       sig_i,
   input  logic [1:0] mode_i,
   input  logic       clr_i,
   output logic       lvl_o,
   output logic       rise_o,
   output logic       fall_o,
   output logic       flag_o
);

   localparam int unsigned      CntW   = cnt_width(FILTER_LEN);
   localparam logic [CntW-1:0] CntMax = CntW'(FILTER_LEN - 1);
   localparam logic [CntW-1:0] CntOne = CntW'(1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic                   lvl_q, lvl_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;
   logic                   flag_q, flag_d;
   logic                   sy;
   logic                   accept;

   assign sy = sync_q[SYNC_STAGES-1];

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], sig_i};
   end

   // A new level is accepted only after it has been seen FILTER_LEN cycles in a row.
   always_comb begin
      cnt_d  = cnt_q;
      lvl_d  = lvl_q;
      accept = 1'b0;
      if (sy == lvl_q) begin
         cnt_d = '0;
      end else if (cnt_q == CntMax) begin
         lvl_d  = sy;
         cnt_d  = '0;
         accept = 1'b1;
      end else begin
         cnt_d = cnt_q + CntOne;
      end
   end

   always_comb begin
      rise_d = accept &  sy & mode_i[0];
      fall_d = accept & ~sy & mode_i[1];
      // A new event wins over a clear arriving in the same cycle.
      flag_d = (flag_q & ~clr_i) | rise_d | fall_d;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= {SYNC_STAGES{RST_LVL}};
         cnt_q  <= '0;
         lvl_q  <= RST_LVL;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         flag_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         cnt_q  <= cnt_d;
         lvl_q  <= lvl_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
         flag_q <= flag_d;
      end
   end

   assign lvl_o  = lvl_q;
   assign rise_o = rise_q;
   assign fall_o = fall_q;
   assign flag_o = flag_q;

endmodule

// File: rtl/edge_det_multi.sv
// Multi-channel edge detector for asynchronous pins: NCH independent channels,
// each with its own 2-bit mode field and sticky-flag clear.
module edge_det_multi
   import edge_det_pkg::*;
#(
   parameter int unsigned NCH         = 4,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILTER_LEN  = 1,
   parameter logic        RST_LVL     = 1'b0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [NCH-1:0]   sig_i,
   input  logic [2*NCH-1:0] mode_i,
   input  logic [NCH-1:0]   clr_i,
   output logic [NCH-1:0]   lvl_o,
   output logic [NCH-1:0]   rise_o,
   output logic [NCH-1:0]   fall_o,
   output logic [NCH-1:0]   evt_o,
   output logic [NCH-1:0]   flag_o
);

   for (genvar i = 0; i < NCH; i++) begin : g_chan
      edge_det_chan #(
         .SYNC_STAGES (SYNC_STAGES),
         .FILTER_LEN  (FILTER_LEN),
         .RST_LVL     (RST_LVL)
      ) u_chan (
         .clk_i  (clk_i),
         .rst_i  (rst_i),
         .sig_i  (sig_i[i]),
         .mode_i (mode_i[2*i +: 2]),
         .clr_i  (clr_i[i]),
         .lvl_o  (lvl_o[i]),
         .rise_o (rise_o[i]),
         .fall_o (fall_o[i]),
         .flag_o (flag_o[i])
      );
   end

   // Only combinational output: both inputs are already registered.
   assign evt_o = rise_o | fall_o;

endmodule

// File: tb/tb_edge_det_multi.sv
// Scoreboard bench for edge_det_multi: three instances (FILTER_LEN 1, 4, 8),
// expectations queued per cycle as stimulus is planned, compared at negedge.
module tb_edge_det_multi;
   import edge_det_pkg::*;

   localparam int unsigned N = 4;

   typedef struct packed {
      logic [N-1:0] lvl;
      logic [N-1:0] rise;
      logic [N-1:0] fall;
      logic [N-1:0] flag;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst_a, rst_b, rst_c;
   logic [N-1:0]   sig_a, sig_b, sig_c;
   logic [2*N-1:0] mode_a, mode_b, mode_c;
   logic [N-1:0]   clr_a, clr_b, clr_c;
   logic [N-1:0]   lvl_a, rise_a, fall_a, evt_a, flag_a;
   logic [N-1:0]   lvl_b, rise_b, fall_b, evt_b, flag_b;
   logic [N-1:0]   lvl_c, rise_c, fall_c, evt_c, flag_c;

   edge_det_multi #(.NCH(N), .SYNC_STAGES(2), .FILTER_LEN(1), .RST_LVL(1'b0)) dut_a (
      .clk_i(clk), .rst_i(rst_a), .sig_i(sig_a), .mode_i(mode_a), .clr_i(clr_a),
      .lvl_o(lvl_a), .rise_o(rise_a), .fall_o(fall_a), .evt_o(evt_a), .flag_o(flag_a)
   );
   edge_det_multi #(.NCH(N), .SYNC_STAGES(2), .FILTER_LEN(4), .RST_LVL(1'b0)) dut_b (
      .clk_i(clk), .rst_i(rst_b), .sig_i(sig_b), .mode_i(mode_b), .clr_i(clr_b),
      .lvl_o(lvl_b), .rise_o(rise_b), .fall_o(fall_b), .evt_o(evt_b), .flag_o(flag_b)
   );
   edge_det_multi #(.NCH(N), .SYNC_STAGES(2), .FILTER_LEN(8), .RST_LVL(1'b0)) dut_c (
      .clk_i(clk), .rst_i(rst_c), .sig_i(sig_c), .mode_i(mode_c), .clr_i(clr_c),
      .lvl_o(lvl_c), .rise_o(rise_c), .fall_o(fall_c), .evt_o(evt_c), .flag_o(flag_c)
   );

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic push(input logic [N-1:0] l, input logic [N-1:0] r,
                       input logic [N-1:0] f, input logic [N-1:0] fl);
      exp_t e;
      e.lvl  = l;
      e.rise = r;
      e.fall = f;
      e.flag = fl;
      sb.push_back(e);
   endtask

   task automatic test_reset();
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      sig_a = '0; sig_b = '0; sig_c = '0;
      mode_a = '0; mode_b = '0; mode_c = '0;
      clr_a = '0; clr_b = '0; clr_c = '0;
      repeat (3) tick();
      checks++;
      if ({lvl_a, rise_a, fall_a, evt_a, flag_a} !== 20'h0) begin
         errors++;
         $display("FAIL reset_a: got %h, exp 00000", {lvl_a, rise_a, fall_a, evt_a, flag_a});
      end
      checks++;
      if ({lvl_b, rise_b, fall_b, evt_b, flag_b} !== 20'h0) begin
         errors++;
         $display("FAIL reset_b: got %h, exp 00000", {lvl_b, rise_b, fall_b, evt_b, flag_b});
      end
      checks++;
      if ({lvl_c, rise_c, fall_c, evt_c, flag_c} !== 20'h0) begin
         errors++;
         $display("FAIL reset_c: got %h, exp 00000", {lvl_c, rise_c, fall_c, evt_c, flag_c});
      end
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
   endtask

   // ch0 rise-only, sig[0] 0->1: pulse exactly on the third edge.
   task automatic test_rise_default();
      exp_t e;
      mode_a   = {MODE_OFF, MODE_OFF, MODE_OFF, MODE_RISE};
      sig_a[0] = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         if (k < 3) push(4'b0000, 4'b0000, 4'b0000, 4'b0000);
         else       push(4'b0001, (k == 3) ? 4'b0001 : 4'b0000, 4'b0000, 4'b0001);
      end
      for (int k = 1; k <= 6; k++) begin
         tick();
         e = sb.pop_front();
         checks++;
         if ({lvl_a, rise_a, fall_a, evt_a, flag_a} !==
             {e.lvl, e.rise, e.fall, e.rise | e.fall, e.flag}) begin
            errors++;
            $display("FAIL rise_default tick %0d: got lvl=%b rise=%b fall=%b evt=%b flag=%b, exp lvl=%b rise=%b fall=%b evt=%b flag=%b",
                     k, lvl_a, rise_a, fall_a, evt_a, flag_a,
                     e.lvl, e.rise, e.fall, e.rise | e.fall, e.flag);
         end
      end
   endtask

   // Fall on rise-only ch0 is silent; then clr collides with a new rise, then clr alone.
   task automatic test_flag_clear();
      exp_t e;
      sig_a[0] = 1'b0;
      for (int k = 1; k <= 11; k++) begin
         if (k <= 2)      push(4'b0001, 4'b0000, 4'b0000, 4'b0001);
         else if (k <= 7) push(4'b0000, 4'b0000, 4'b0000, 4'b0001);
         else if (k == 8) push(4'b0001, 4'b0001, 4'b0000, 4'b0001);
         else             push(4'b0001, 4'b0000, 4'b0000, 4'b0000);
      end
      for (int k = 1; k <= 11; k++) begin
         tick();
         e = sb.pop_front();
         checks++;
         if ({lvl_a, rise_a, fall_a, evt_a, flag_a} !==
             {e.lvl, e.rise, e.fall, e.rise | e.fall, e.flag}) begin
            errors++;
            $display("FAIL flag_clear tick %0d: got lvl=%b rise=%b fall=%b evt=%b flag=%b, exp lvl=%b rise=%b fall=%b evt=%b flag=%b",
                     k, lvl_a, rise_a, fall_a, evt_a, flag_a,
                     e.lvl, e.rise, e.fall, e.rise | e.fall, e.flag);
         end
         if (k == 5) sig_a[0] = 1'b1;
         if (k == 7) clr_a[0] = 1'b1;
         if (k == 9) clr_a[0] = 1'b0;
      end
   endtask

   // ch2 fall-only, then off: lvl follows in both cases.
   task automatic test_fall_mode();
      exp_t         e;
      logic [N-1:0] l;
      mode_a   = {MODE_OFF, MODE_FALL, MODE_OFF, MODE_RISE};
      sig_a[2] = 1'b1;
      for (int k = 1; k <= 60; k++) begin
         l    = 4'b0001;
         l[2] = ((k >= 3) && (k < 23)) || ((k >= 43) && (k < 53));
         push(l, 4'b0000, (k == 23) ? 4'b0100 : 4'b0000, (k >= 23) ? 4'b0100 : 4'b0000);
      end
      for (int k = 1; k <= 60; k++) begin
         tick();
         e = sb.pop_front();
         checks++;
         if ({lvl_a, rise_a, fall_a, evt_a, flag_a} !==
             {e.lvl, e.rise, e.fall, e.rise | e.fall, e.flag}) begin
            errors++;
            $display("FAIL fall_mode tick %0d: got lvl=%b rise=%b fall=%b evt=%b flag=%b, exp lvl=%b rise=%b fall=%b evt=%b flag=%b",
                     k, lvl_a, rise_a, fall_a, evt_a, flag_a,
                     e.lvl, e.rise, e.fall, e.rise | e.fall, e.flag);
         end
         if (k == 20) sig_a[2] = 1'b0;
         if (k == 40) begin
            mode_a   = {MODE_OFF, MODE_OFF, MODE_OFF, MODE_RISE};
            sig_a[2] = 1'b1;
         end
         if (k == 50) sig_a[2] = 1'b0;
      end
   endtask

   // Clear all flags, then every channel rises and falls together in mode both.
   task automatic test_all_rise();
      exp_t e;
      sig_a = 4'b0000;
      clr_a = 4'b1111;
      for (int k = 1; k <= 18; k++) begin
         if (k <= 2)       push(4'b0001, 4'b0000, 4'b0000, 4'b0000);
         else if (k <= 7)  push(4'b0000, 4'b0000, 4'b0000, 4'b0000);
         else if (k == 8)  push(4'b1111, 4'b1111, 4'b0000, 4'b1111);
         else if (k <= 14) push(4'b1111, 4'b0000, 4'b0000, 4'b1111);
         else if (k == 15) push(4'b0000, 4'b0000, 4'b1111, 4'b1111);
         else              push(4'b0000, 4'b0000, 4'b0000, 4'b1111);
      end
      for (int k = 1; k <= 18; k++) begin
         tick();
         e = sb.pop_front();
         checks++;
         if ({lvl_a, rise_a, fall_a, evt_a, flag_a} !==
             {e.lvl, e.rise, e.fall, e.rise | e.fall, e.flag}) begin
            errors++;
            $display("FAIL all_rise tick %0d: got lvl=%b rise=%b fall=%b evt=%b flag=%b, exp lvl=%b rise=%b fall=%b evt=%b flag=%b",
                     k, lvl_a, rise_a, fall_a, evt_a, flag_a,
                     e.lvl, e.rise, e.fall, e.rise | e.fall, e.flag);
         end
         if (k == 1) clr_a = 4'b0000;
         if (k == 5) begin
            mode_a = {MODE_BOTH, MODE_BOTH, MODE_BOTH, MODE_BOTH};
            sig_a  = 4'b1111;
         end
         if (k == 12) sig_a = 4'b0000;
      end
   endtask

   // FILTER_LEN=4: a 3-cycle pulse is rejected, a 4-cycle pulse gives rise and fall.
   task automatic test_glitch_filter();
      exp_t e;
      mode_b   = {MODE_BOTH, MODE_BOTH, MODE_BOTH, MODE_BOTH};
      sig_b[1] = 1'b1;
      for (int k = 1; k <= 24; k++) begin
         if (k < 16)       push(4'b0000, 4'b0000, 4'b0000, 4'b0000);
         else if (k == 16) push(4'b0010, 4'b0010, 4'b0000, 4'b0010);
         else if (k < 20)  push(4'b0010, 4'b0000, 4'b0000, 4'b0010);
         else if (k == 20) push(4'b0000, 4'b0000, 4'b0010, 4'b0010);
         else              push(4'b0000, 4'b0000, 4'b0000, 4'b0010);
      end
      for (int k = 1; k <= 24; k++) begin
         tick();
         e = sb.pop_front();
         checks++;
         if ({lvl_b, rise_b, fall_b, evt_b, flag_b} !==
             {e.lvl, e.rise, e.fall, e.rise | e.fall, e.flag}) begin
            errors++;
            $display("FAIL glitch_filter tick %0d: got lvl=%b rise=%b fall=%b evt=%b flag=%b, exp lvl=%b rise=%b fall=%b evt=%b flag=%b",
                     k, lvl_b, rise_b, fall_b, evt_b, flag_b,
                     e.lvl, e.rise, e.fall, e.rise | e.fall, e.flag);
         end
         if (k == 3)  sig_b[1] = 1'b0;
         if (k == 10) sig_b[1] = 1'b1;
         if (k == 14) sig_b[1] = 1'b0;
      end
   endtask

   // FILTER_LEN=8: reset mid-count discards progress; sig held high through reset
   // yields a rise SYNC_STAGES+FILTER_LEN edges after release.
   task automatic test_reset_abort();
      exp_t e;
      mode_c   = {MODE_BOTH, MODE_BOTH, MODE_BOTH, MODE_BOTH};
      sig_c[3] = 1'b1;
      for (int k = 1; k <= 19; k++) begin
         if (k < 17)       push(4'b0000, 4'b0000, 4'b0000, 4'b0000);
         else if (k == 17) push(4'b1000, 4'b1000, 4'b0000, 4'b1000);
         else              push(4'b1000, 4'b0000, 4'b0000, 4'b1000);
      end
      for (int k = 1; k <= 19; k++) begin
         tick();
         e = sb.pop_front();
         checks++;
         if ({lvl_c, rise_c, fall_c, evt_c, flag_c} !==
             {e.lvl, e.rise, e.fall, e.rise | e.fall, e.flag}) begin
            errors++;
            $display("FAIL reset_abort tick %0d: got lvl=%b rise=%b fall=%b evt=%b flag=%b, exp lvl=%b rise=%b fall=%b evt=%b flag=%b",
                     k, lvl_c, rise_c, fall_c, evt_c, flag_c,
                     e.lvl, e.rise, e.fall, e.rise | e.fall, e.flag);
         end
         if (k == 5) rst_c = 1'b1;
         if (k == 7) rst_c = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_rise_default();
      test_flag_clear();
      test_fall_mode();
      test_all_rise();
      test_glitch_filter();
      test_reset_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/edge_det_multi.md
Name: edge_det_multi

Overview:
- Parametrised multi-channel edge detector for asynchronous pins (SPI SCK, CS_N, MOSI and auxiliary strobes) feeding the spi_slave core.
- Per channel: configurable-depth synchroniser, stable-count glitch filter, per-channel rise/fall/both selection, one-cycle pulse outputs.
- Also provides sticky per-channel event flags with individual clear, for status registers.
- Replaces single-channel, unfiltered, rise-only detection.

Parameters:
- NCH, 4, number of independent channels.
- SYNC_STAGES, 2, synchroniser flops per channel; legal range 2..4.
- FILTER_LEN, 1, consecutive cycles a new synchronised level must persist before acceptance; legal range 1..255. 1 = no filtering.
- RST_LVL, 0, filtered level loaded by reset (scalar, all channels).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- sig  in  NCH  asynchronous input signals.
- mode  in  2*NCH  per-channel mode; channel i uses bits [2i+1:2i]. 00 = off, 01 = rise, 10 = fall, 11 = both.
- clr  in  NCH  per-channel sticky-flag clear.
- lvl  out  NCH  filtered, synchronised level.
- rise  out  NCH  one-cycle pulse on an accepted 0->1 transition (gated by mode bit 0).
- fall  out  NCH  one-cycle pulse on an accepted 1->0 transition (gated by mode bit 1).
- evt  out  NCH  rise | fall.
- flag  out  NCH  sticky event flag.

Behaviour:
- One clock; reset is synchronous and active-high on rst. Every output is registered except evt, which is the OR of registered rise and fall.
- Reset values:
  - synchroniser flops = RST_LVL
  - filter counter = 0
  - lvl = RST_LVL
  - rise, fall, evt, flag = 0
- Reset asserted mid-operation aborts any in-progress filter count. No pulse is emitted in the reset cycle or the cycle after it.
- Synchroniser: s[0] <= sig[i]; s[k] <= s[k-1]. The filter observes sy = s[SYNC_STAGES-1].
- Filter per channel:
  - Counter width = clog2(FILTER_LEN+1).
  - If sy == lvl: cnt <= 0.
  - Else if cnt == FILTER_LEN-1: lvl <= sy, cnt <= 0, and the edge is accepted this cycle.
  - Else: cnt <= cnt+1.
  - A glitch shorter than FILTER_LEN cycles (post-synchroniser) resets cnt and produces no edge.
- Pulses: rise <= accepted & sy & mode[2i]; fall <= accepted & ~sy & mode[2i+1]. Otherwise both are 0 the next cycle.
  - Mode is sampled in the acceptance cycle.
  - Mode change never generates a pulse by itself.
  - lvl tracks the input even with mode = off.
- Latency: sig stable before edge E1 -> lvl and the pulse are updated at edge E(SYNC_STAGES+FILTER_LEN). Defaults: 3 cycles.
- Pulse width is exactly 1 cycle. Minimum spacing between accepted edges on one channel is FILTER_LEN cycles.
- Sticky flag:
  - flag <= (flag & ~clr) | evt_next.
  - Set wins over a simultaneous clear.
  - clr with no event clears next cycle.
- Channels are fully independent; simultaneous edges on all channels are all reported in the same cycle.
- sig held at ~RST_LVL through reset is reported as an edge after release; this is intentional.

Decomposition:
- Shared package edge_det_pkg:
  - MODE_OFF / MODE_RISE / MODE_FALL / MODE_BOTH 2-bit constants.
  - cnt-width function.
- Sub-module edge_det_chan holds one channel (sync, filter, pulse, flag). The top generates NCH instances and slices mode.

Test Plan:
- Defaults, mode=01 on ch0, sig[0] 0->1 at cycle 10 -> rise[0] high for exactly cycle 13; lvl[0]=1 from 13; fall[0] stays 0; flag[0]=1 from 13.
- FILTER_LEN=4, mode=11, sig[1] high for 3 cycles then low -> no pulse, lvl[1]=0. Then high for 4 cycles -> rise[1] at cycle +6 (2 sync + 4 filter); fall[1] after return low +6.
- mode=10 on ch2, toggle sig[2] 0->1->0 with 20 cycles spacing -> only fall[2] pulses; lvl[2] follows both; mode=00 -> no pulses, lvl still follows.
- All 4 channels rise together, mode=11 -> rise=4'b1111 in same cycle, evt=4'b1111.
- clr[0] asserted in the same cycle a new rise[0] registers -> flag[0] remains 1. clr[0] alone the next cycle -> flag[0]=0 the following cycle.
- rst asserted during FILTER_LEN=8 count on ch3 -> counter cleared, no pulse. sig[3]=1 held through reset with RST_LVL=0 -> rise[3] at SYNC_STAGES+FILTER_LEN cycles after release.
